pipelined_adder_sub: RTL and testbench

//   Parametrised, pipelined ripple adder/subtractor; next generation of the ripple adders.

---
 rtl/pipelined_adder_sub.sv | 114 +++++++++++
 tb/tb_pipelined_adder_sub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple adder/subtractor: one CHUNK-bit slice per stage, registered inter-stage carry.
// Optional signed saturation when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder_sub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (WIDTH % STAGES != 0) begin : g_width_check
    $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES");
  end

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [WIDTH-1:0]  r_n [STAGES];
  logic [CHUNK:0]    sum [STAGES];
  logic [STAGES-1:0] c_s;
  logic [STAGES-1:0] c_n;

  logic             stall;
  logic             ovf;
  logic [WIDTH-1:0] res;

  assign stall   = v_q[LAST] && !i_ready;
  assign o_ready = !stall;

  // Stage 0 sees the (possibly inverted) operands directly; later stages see the previous register.
  always_comb begin
    a_s[0] = i_add1;
    b_s[0] = i_sub ? ~i_add2 : i_add2;
    r_s[0] = '0;
    c_s    = '0;
    c_s[0] = i_carry ^ i_sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      r_s[k] = r_q[k-1];
      c_s[k] = c_q[k-1];
    end
    c_n = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, a_s[k][k*CHUNK +: CHUNK]} + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_s[k]};
      r_n[k] = r_s[k];
      r_n[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
      c_n[k] = sum[k][CHUNK];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= i_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      c_q <= c_n;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_s[k];
        b_q[k] <= b_s[k];
        r_q[k] <= r_n[k];
      end
    end
  end

  // Overflow and saturation are derived from the last stage's held operands, so they stay stable on stall.
  always_comb begin
    ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) && (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    if (ovf) begin
      res = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = r_q[LAST];
    end
`else
    res = r_q[LAST];
`endif
  end

  assign o_valid    = v_q[LAST];
  assign o_result   = v_q[LAST] ? res : '0;
  assign o_carry    = v_q[LAST] && c_q[LAST];
  assign o_overflow = v_q[LAST] && ovf;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Self-checking bench for pipelined_adder_sub (WIDTH=8, STAGES=2) against an arithmetic reference model.
module tb_pipelined_adder_sub;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int MAXV   = (1 << WIDTH) - 1;

  typedef logic [WIDTH+1:0] exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             dst_valid;
  logic             dst_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;

  int unsigned checks = 0;
  int unsigned passes = 0;
  exp_t        exp_q[$];

  logic             have;
  logic [WIDTH-1:0] na;
  logic [WIDTH-1:0] nb;
  logic             nc;
  logic             ns;

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (src_valid),
    .o_ready    (src_ready),
    .i_add1     (op_a),
    .i_add2     (op_b),
    .i_carry    (cin),
    .i_sub      (sub),
    .o_valid    (dst_valid),
    .i_ready    (dst_ready),
    .o_result   (res),
    .o_carry    (cout),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  // Integer arithmetic: unsigned result for value/carry, signed result for overflow range.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    int full;
    int sres;
    logic [WIDTH-1:0] r;
    logic co;
    logic ov;
    if (s) begin
      full = int'(a) - int'(b) - int'(c);
      co   = (full >= 0);
      sres = int'($signed(a)) - int'($signed(b)) - int'(c);
    end else begin
      full = int'(a) + int'(b) + int'(c);
      co   = (full > MAXV);
      sres = int'($signed(a)) + int'($signed(b)) + int'(c);
    end
    r  = full[WIDTH-1:0];
    ov = (sres > (MAXV >> 1)) || (sres < -((MAXV >> 1) + 1));
`ifdef PIPELINED_ADDER_SAT_EN
    if (ov) r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {ov, co, r};
  endfunction

  task automatic set_in(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s, input logic r);
    src_valid = v;
    op_a      = a;
    op_b      = b;
    cin       = c;
    sub       = s;
    dst_ready = r;
  endtask

  task automatic new_op;
    na = WIDTH'($urandom);
    nb = WIDTH'($urandom);
    nc = 1'($urandom_range(0, 1));
    ns = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    set_in(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dst_valid); else passes++;
    checks++; if (res !== '0) $display("FAIL reset_result: got %h want 00", res); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL reset_carry: got %b want 0", cout); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passes++;
    checks++; if (src_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", src_ready); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] ta [6] = '{8'hFF, 8'h0F, 8'h7F, 8'h05, 8'h80, 8'h10};
    logic [WIDTH-1:0] tb [6] = '{8'h01, 8'h00, 8'h01, 8'h07, 8'h01, 8'h10};
    logic             tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic             ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef PIPELINED_ADDER_SAT_EN
    exp_t te [6] = '{{2'b01, 8'h00}, {2'b00, 8'h10}, {2'b10, 8'h7F},
                     {2'b00, 8'hFE}, {2'b11, 8'h80}, {2'b00, 8'hFF}};
`else
    exp_t te [6] = '{{2'b01, 8'h00}, {2'b00, 8'h10}, {2'b10, 8'h80},
                     {2'b00, 8'hFE}, {2'b11, 8'h7F}, {2'b00, 8'hFF}};
`endif
    int   lat;
    exp_t act;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
      @(posedge clk); #1;
      src_valid = 1'b0;
      lat = 1;
      while (!dst_valid && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      act = {ovf, cout, res};
      checks++; if (lat != STAGES) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, STAGES); else passes++;
      checks++; if (act[WIDTH-1:0] !== te[i][WIDTH-1:0]) $display("FAIL directed_result[%0d]: got %h want %h", i, act[WIDTH-1:0], te[i][WIDTH-1:0]); else passes++;
      checks++; if (act[WIDTH] !== te[i][WIDTH]) $display("FAIL directed_carry[%0d]: got %b want %b", i, act[WIDTH], te[i][WIDTH]); else passes++;
      checks++; if (act[WIDTH+1] !== te[i][WIDTH+1]) $display("FAIL directed_ovf[%0d]: got %b want %b", i, act[WIDTH+1], te[i][WIDTH+1]); else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    exp_t act;
    exp_t e;
    exp_q.delete();
    have = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(posedge clk); #1;
      if (!have && sent < 6) begin new_op; have = 1'b1; end
      set_in(have, na, nb, nc, ns, !(cyc >= 3 && cyc < 6));
      @(negedge clk);
      act = {ovf, cout, res};
      if (dst_valid && !dst_ready) begin
        checks++; if (src_ready !== 1'b0) $display("FAIL b2b_ready_on_stall: got %b want 0", src_ready); else passes++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_stall_hold: got %h want none", act);
        else if (act !== exp_q[0]) $display("FAIL b2b_stall_hold: got %h want %h", act, exp_q[0]);
        else passes++;
      end
      if (dst_valid && dst_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_spurious: got %h want none", act);
        else begin
          e = exp_q.pop_front();
          if (act !== e) $display("FAIL b2b_result[%0d]: got %h want %h", got, act, e); else passes++;
        end
        got++;
      end
      if (src_valid && src_ready) begin
        exp_q.push_back(model(na, nb, nc, ns));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    checks++; if (got != 6 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d left %0d want 6 left 0", got, exp_q.size()); else passes++;
  endtask

  task automatic test_random;
    int   n = 10000;
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    exp_t act;
    exp_t e;
    exp_q.delete();
    have = 1'b0;
    while (got < n && cyc < 60000) begin
      @(posedge clk); #1;
      if (!have && sent < n && $urandom_range(0, 99) < 70) begin new_op; have = 1'b1; end
      set_in(have, na, nb, nc, ns, $urandom_range(0, 99) < 75);
      @(negedge clk);
      act = {ovf, cout, res};
      if (!dst_valid) begin
        checks++; if (act !== '0) $display("FAIL random_idle_outputs: got %h want 0", act); else passes++;
      end
      if (dst_valid && dst_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL random_spurious: got %h want none", act);
        else begin
          e = exp_q.pop_front();
          if (act !== e) $display("FAIL random_result[%0d]: got %h want %h", got, act, e); else passes++;
        end
        got++;
      end
      if (src_valid && src_ready) begin
        exp_q.push_back(model(na, nb, nc, ns));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    checks++; if (got != n || exp_q.size() != 0) $display("FAIL random_count: got %0d left %0d want %0d left 0", got, exp_q.size(), n); else passes++;
  endtask

  task automatic test_reset_midstream;
    int   lat;
    exp_t act;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      new_op;
      set_in(1'b1, na, nb, nc, ns, 1'b0);
    end
    @(negedge clk);
    checks++; if (dst_valid !== 1'b1 || src_ready !== 1'b0) $display("FAIL mid_full_stall: got v=%b r=%b want v=1 r=0", dst_valid, src_ready); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (dst_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", dst_valid); else passes++;
    checks++; if ({ovf, cout, res} !== '0) $display("FAIL mid_reset_outputs: got %h want 0", {ovf, cout, res}); else passes++;
    checks++; if (src_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", src_ready); else passes++;
    @(posedge clk); #1;
    new_op;
    set_in(1'b1, na, nb, nc, ns, 1'b1);
    e = model(na, nb, nc, ns);
    @(posedge clk); #1;
    src_valid = 1'b0;
    lat = 1;
    while (!dst_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    act = {ovf, cout, res};
    checks++; if (lat != STAGES) $display("FAIL mid_first_latency: got %0d want %0d", lat, STAGES); else passes++;
    checks++; if (act !== e) $display("FAIL mid_first_result: got %h want %h", act, e); else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
